tag_check_unit: RTL and testbench
=================================

// Module: tag_check_unit
// PURPOSE
//  Downstream consumer of the keyed tag generator. On writes it stores the generated
//  tag for an address in a tag RAM. On reads it compares the freshly generated tag of
//  the returned data with the stored tag and flags integrity violations.
//  Single outstanding request with valid/ready request and response channels.
// PARAMETERS
//  TAG_SIZE    8   width of a tag; must match the generator's TAG_SIZE
//  ADDR_WIDTH  6   tag RAM index width; depth = 2**ADDR_WIDTH entries
//  CNT_WIDTH   16  width of the saturating mismatch counter
// PORTS
//  clk            in   1           clock; all logic on the rising edge
//  reset          in   1           reset, synchronous, active-high
//  req_valid      in   1           request present
//  req_ready      out  1           unit can accept a request; high only in IDLE
//  req_write      in   1           1 = store tag, 0 = check tag
//  req_addr       in   ADDR_WIDTH  tag RAM index
//  req_tag        in   TAG_SIZE    generator tag for this request's data
//  resp_valid     out  1           response present; held until resp_ready
//  resp_ready     in   1           downstream accepts the response
//  resp_write     out  1           echo of req_write
//  resp_ok        out  1           write acked, or read tag matched
//  resp_mismatch  out  1           read of a written entry with differing tag
//  resp_unwritten out  1           read of an entry never written since reset
//  err_count      out  CNT_WIDTH   saturating count of mismatches
// BEHAVIOUR
//  - Reset: state=IDLE; req_ready=1 in the next cycle; resp_valid, resp_* = 0;
//    err_count=0; all per-entry valid bits cleared. RAM contents are not cleared.
//  - FSM states: IDLE, LOOKUP, COMPARE, RESP.
//    IDLE    : req_ready=1. On req_valid, capture write/addr/tag.
//              write -> RESP; read -> LOOKUP.
//    LOOKUP  : synchronous RAM read issued at the captured addr -> COMPARE.
//    COMPARE : the RAM word and the valid bit are available. The result is registered -> RESP.
//    RESP    : resp_valid=1 and resp_* stable. On resp_ready -> IDLE.
//  - Write: the RAM[addr] update and valid[addr]=1 happen on the accept edge.
//    Response: resp_ok=1, resp_write=1. resp_valid is high in the cycle after accept.
//  - Read: resp_valid is high 3 cycles after accept.
//    valid[addr]=0        -> resp_unwritten=1, resp_ok=0, resp_mismatch=0; no count.
//    stored == req_tag    -> resp_ok=1.
//    otherwise            -> resp_mismatch=1, resp_ok=0.
//  - Exactly one of {ok, mismatch, unwritten} is high in any read response.
//  - err_count increments on the COMPARE->RESP edge when a mismatch is found.
//    It saturates at 2**CNT_WIDTH-1 and never wraps.
//  - Zero-wait back-to-back: a request may be accepted in the cycle after the
//    RESP handshake.
//  - resp_ready held high does not skip RESP; RESP lasts at least one cycle.
//  - Reset asserted mid-operation aborts any in-flight request with no response.
//    A write whose accept edge coincides with reset is discarded.
// CONFIGURATION
//  TAG_CHECK_IRQ_EN defined:
//    - Adds outputs err_irq (1) and err_addr (ADDR_WIDTH), plus input irq_clr (1).
//    - The first mismatch sets sticky err_irq=1 and latches its addr into err_addr.
//    - Later mismatches do not overwrite err_addr until irq_clr.
//    - irq_clr clears err_irq and err_addr the next cycle and wins over a same-cycle
//      mismatch (that mismatch still counts).
//    - Both outputs are 0 at reset.
//  TAG_CHECK_IRQ_EN undefined: none of these ports or registers exist; behaviour
//  is otherwise identical.
// TESTING
//  1 Write addr 5, tag 0xA3; read addr 5, tag 0xA3
//    -> write resp 1 cycle after accept with ok=1; read resp 3 cycles later,
//       ok=1, err_count=0.
//  2 Read addr 5 with tag 0xA2 after test 1
//    -> mismatch=1, ok=0, err_count=1; with IRQ_EN: err_irq=1, err_addr=5.
//  3 Read addr 9 never written -> unwritten=1, ok=0, mismatch=0, err_count unchanged.
//  4 Hold resp_ready=0 for 4 cycles -> resp_valid and resp_* stable, req_ready=0,
//    and a new req_valid is ignored.
//  5 Force err_count to all-ones minus 1 then run 3 mismatches
//    -> err_count = 0xFFFF and stays there.
//  6 Assert reset in LOOKUP -> no response; next cycle req_ready=1, err_count=0;
//    a read of a previously written addr returns unwritten=1.

Source files
------------

// File: rtl/tag_check_if.sv
// Request/response channel between a tag requester and tag_check_unit.
// The master drives requests and consumes responses; the slave is the checker.
interface tag_check_if #(
    parameter int TAG_SIZE   = 8,
    parameter int ADDR_WIDTH = 6
) ();
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [TAG_SIZE-1:0]   req_tag;
    logic                  resp_valid;
    logic                  resp_ready;
    logic                  resp_write;
    logic                  resp_ok;
    logic                  resp_mismatch;
    logic                  resp_unwritten;

    modport master (
        output req_valid, req_write, req_addr, req_tag, resp_ready,
        input  req_ready, resp_valid, resp_write, resp_ok, resp_mismatch, resp_unwritten
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_tag, resp_ready,
        output req_ready, resp_valid, resp_write, resp_ok, resp_mismatch, resp_unwritten
    );
endinterface

// File: rtl/tag_check_unit.sv
// Tag RAM checker: stores generator tags on writes, compares them on reads and counts mismatches.
// Optional TAG_CHECK_IRQ_EN adds a sticky mismatch interrupt with the first failing address.
//
//  state   | meaning
//  IDLE    | ready for a request; writes update the RAM on the accept edge
//  LOOKUP  | synchronous RAM read at the captured address
//  COMPARE | stored tag and valid bit available; result registered
//  RESP    | response held until resp_ready
module tag_check_unit #(
    parameter int TAG_SIZE   = 8,
    parameter int ADDR_WIDTH = 6,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    tag_check_if.slave            bus,
    output logic [CNT_WIDTH-1:0]  err_count
`ifdef TAG_CHECK_IRQ_EN
    ,
    input  logic                  irq_clr,
    output logic                  err_irq,
    output logic [ADDR_WIDTH-1:0] err_addr
`endif
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic [1:0] {IDLE, LOOKUP, COMPARE, RESP} state_t;

    state_t                state_q, state_d;
    logic                  cap_write_q, cap_write_d;
    logic [ADDR_WIDTH-1:0] cap_addr_q, cap_addr_d;
    logic [TAG_SIZE-1:0]   cap_tag_q, cap_tag_d;
    logic                  rd_valid_q, rd_valid_d;
    logic [DEPTH-1:0]      valid_q, valid_d;
    logic                  resp_write_q, resp_write_d;
    logic                  resp_ok_q, resp_ok_d;
    logic                  resp_mismatch_q, resp_mismatch_d;
    logic                  resp_unwritten_q, resp_unwritten_d;
    logic [CNT_WIDTH-1:0]  err_count_q, err_count_d;
    logic                  ram_we;
    logic                  mismatch_evt;
    logic                  req_ready;
    logic                  resp_valid;

    // RAM contents survive reset; only the per-entry valid bits are cleared.
    logic [TAG_SIZE-1:0]   tag_ram [DEPTH];
    logic [TAG_SIZE-1:0]   ram_rdata;

    always_ff @(posedge clk) begin
        if (ram_we && !reset) tag_ram[bus.req_addr] <= bus.req_tag;
        if (state_q == LOOKUP) ram_rdata <= tag_ram[cap_addr_q];
    end

    always_comb begin
        state_d          = state_q;
        cap_write_d      = cap_write_q;
        cap_addr_d       = cap_addr_q;
        cap_tag_d        = cap_tag_q;
        rd_valid_d       = rd_valid_q;
        valid_d          = valid_q;
        resp_write_d     = resp_write_q;
        resp_ok_d        = resp_ok_q;
        resp_mismatch_d  = resp_mismatch_q;
        resp_unwritten_d = resp_unwritten_q;
        err_count_d      = err_count_q;
        ram_we           = 1'b0;
        mismatch_evt     = 1'b0;
        req_ready        = 1'b0;
        resp_valid       = 1'b0;

        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (bus.req_valid) begin
                    cap_write_d = bus.req_write;
                    cap_addr_d  = bus.req_addr;
                    cap_tag_d   = bus.req_tag;
                    if (bus.req_write) begin
                        ram_we                = 1'b1;
                        valid_d[bus.req_addr] = 1'b1;
                        resp_write_d          = 1'b1;
                        resp_ok_d             = 1'b1;
                        resp_mismatch_d       = 1'b0;
                        resp_unwritten_d      = 1'b0;
                        state_d               = RESP;
                    end else begin
                        state_d = LOOKUP;
                    end
                end
            end
            LOOKUP: begin
                rd_valid_d = valid_q[cap_addr_q];
                state_d    = COMPARE;
            end
            COMPARE: begin
                resp_write_d     = cap_write_q;
                resp_ok_d        = 1'b0;
                resp_mismatch_d  = 1'b0;
                resp_unwritten_d = 1'b0;
                if (!rd_valid_q) begin
                    resp_unwritten_d = 1'b1;
                end else if (ram_rdata == cap_tag_q) begin
                    resp_ok_d = 1'b1;
                end else begin
                    resp_mismatch_d = 1'b1;
                    mismatch_evt    = 1'b1;
                end
                state_d = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                if (bus.resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (mismatch_evt && (err_count_q != '1)) err_count_d = err_count_q + CNT_WIDTH'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= IDLE;
            cap_write_q      <= 1'b0;
            cap_addr_q       <= '0;
            cap_tag_q        <= '0;
            rd_valid_q       <= 1'b0;
            valid_q          <= '0;
            resp_write_q     <= 1'b0;
            resp_ok_q        <= 1'b0;
            resp_mismatch_q  <= 1'b0;
            resp_unwritten_q <= 1'b0;
            err_count_q      <= '0;
        end else begin
            state_q          <= state_d;
            cap_write_q      <= cap_write_d;
            cap_addr_q       <= cap_addr_d;
            cap_tag_q        <= cap_tag_d;
            rd_valid_q       <= rd_valid_d;
            valid_q          <= valid_d;
            resp_write_q     <= resp_write_d;
            resp_ok_q        <= resp_ok_d;
            resp_mismatch_q  <= resp_mismatch_d;
            resp_unwritten_q <= resp_unwritten_d;
            err_count_q      <= err_count_d;
        end
    end

    assign bus.req_ready      = req_ready;
    assign bus.resp_valid     = resp_valid;
    assign bus.resp_write     = resp_write_q;
    assign bus.resp_ok        = resp_ok_q;
    assign bus.resp_mismatch  = resp_mismatch_q;
    assign bus.resp_unwritten = resp_unwritten_q;
    assign err_count          = err_count_q;

`ifdef TAG_CHECK_IRQ_EN
    logic                  err_irq_q, err_irq_d;
    logic [ADDR_WIDTH-1:0] err_addr_q, err_addr_d;

    // Clear beats a same-cycle mismatch; only the first mismatch after a clear is latched.
    always_comb begin
        err_irq_d  = err_irq_q;
        err_addr_d = err_addr_q;
        if (irq_clr) begin
            err_irq_d  = 1'b0;
            err_addr_d = '0;
        end else if (mismatch_evt && !err_irq_q) begin
            err_irq_d  = 1'b1;
            err_addr_d = cap_addr_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            err_irq_q  <= 1'b0;
            err_addr_q <= '0;
        end else begin
            err_irq_q  <= err_irq_d;
            err_addr_q <= err_addr_d;
        end
    end

    assign err_irq  = err_irq_q;
    assign err_addr = err_addr_q;
`endif
endmodule

// File: tb/tb_tag_check_unit.sv
// Directed bench for tag_check_unit; a second instance with a 2-bit counter exposes saturation.
// Build with TAG_CHECK_IRQ_EN defined to also exercise the interrupt outputs.
module tb_tag_check_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        irq_clr = 1'b0;
    logic [15:0] err_count;
    logic [1:0]  err_count_s;
    int          n_chk = 0;
    int          n_pass = 0;

    always #5 clk = ~clk;

    tag_check_if #(.TAG_SIZE(8), .ADDR_WIDTH(6)) bus ();
    tag_check_if #(.TAG_SIZE(8), .ADDR_WIDTH(6)) bus_s ();

    assign bus_s.req_valid  = bus.req_valid;
    assign bus_s.req_write  = bus.req_write;
    assign bus_s.req_addr   = bus.req_addr;
    assign bus_s.req_tag    = bus.req_tag;
    assign bus_s.resp_ready = bus.resp_ready;

`ifdef TAG_CHECK_IRQ_EN
    logic       err_irq, err_irq_s;
    logic [5:0] err_addr, err_addr_s;
`endif

    tag_check_unit #(.TAG_SIZE(8), .ADDR_WIDTH(6), .CNT_WIDTH(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus.slave),
        .err_count (err_count)
`ifdef TAG_CHECK_IRQ_EN
        ,
        .irq_clr   (irq_clr),
        .err_irq   (err_irq),
        .err_addr  (err_addr)
`endif
    );

    tag_check_unit #(.TAG_SIZE(8), .ADDR_WIDTH(6), .CNT_WIDTH(2)) dut_s (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus_s.slave),
        .err_count (err_count_s)
`ifdef TAG_CHECK_IRQ_EN
        ,
        .irq_clr   (irq_clr),
        .err_irq   (err_irq_s),
        .err_addr  (err_addr_s)
`endif
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        else n_pass++;
    endtask

    // Issues one request and returns cycles from accept to resp_valid (capped at 20).
    task automatic run_req(input logic w, input logic [5:0] a, input logic [7:0] t, output int lat);
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_write = w;
        bus.req_addr  = a;
        bus.req_tag   = t;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus.resp_valid && lat < 20);
    endtask

    task automatic ack_resp();
        bus.resp_ready = 1'b1;
        @(posedge clk);
        #1 bus.resp_ready = 1'b0;
    endtask

    // Read-and-acknowledge with the full response checked.
    task automatic read_chk(input string name, input logic [5:0] a, input logic [7:0] t,
                            input logic ok, input logic mm, input logic un);
        int lat;
        run_req(1'b0, a, t, lat);
        chk({name, "_lat"}, lat, 3);
        chk({name, "_write"}, bus.resp_write, 1'b0);
        chk({name, "_ok"}, bus.resp_ok, ok);
        chk({name, "_mismatch"}, bus.resp_mismatch, mm);
        chk({name, "_unwritten"}, bus.resp_unwritten, un);
        ack_resp();
    endtask

    task automatic write_chk(input string name, input logic [5:0] a, input logic [7:0] t);
        int lat;
        run_req(1'b1, a, t, lat);
        chk({name, "_lat"}, lat, 1);
        chk({name, "_ok"}, bus.resp_ok, 1'b1);
        chk({name, "_write"}, bus.resp_write, 1'b1);
        ack_resp();
    endtask

    initial begin
        logic [3:0] held;
        int         lat;
        bus.req_valid  = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_addr   = '0;
        bus.req_tag    = '0;
        bus.resp_ready = 1'b0;

        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_req_ready", bus.req_ready, 1'b1);
        chk("rst_resp_valid", bus.resp_valid, 1'b0);
        chk("rst_resp_ok", bus.resp_ok, 1'b0);
        chk("rst_err_count", err_count, 16'h0);
`ifdef TAG_CHECK_IRQ_EN
        chk("rst_err_irq", err_irq, 1'b0);
        chk("rst_err_addr", err_addr, 6'h0);
`endif

        // 1: write then matching read
        write_chk("t1_wr", 6'd5, 8'hA3);
        chk("t1_b2b_ready", bus.req_ready, 1'b1);
        read_chk("t1_rd", 6'd5, 8'hA3, 1'b1, 1'b0, 1'b0);
        chk("t1_err_count", err_count, 16'd0);

        // 2: mismatching read
        read_chk("t2_rd", 6'd5, 8'hA2, 1'b0, 1'b1, 1'b0);
        chk("t2_err_count", err_count, 16'd1);
        chk("t2_err_count_s", err_count_s, 2'd1);
`ifdef TAG_CHECK_IRQ_EN
        chk("t2_err_irq", err_irq, 1'b1);
        chk("t2_err_addr", err_addr, 6'd5);
`endif

        // 3: never-written entry
        read_chk("t3_rd", 6'd9, 8'h00, 1'b0, 1'b0, 1'b1);
        chk("t3_err_count", err_count, 16'd1);

        // 4: backpressure holds the response; a new request is ignored
        run_req(1'b0, 6'd5, 8'hA3, lat);
        chk("t4_lat", lat, 3);
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_addr  = 6'd20;
        bus.req_tag   = 8'h55;
        for (int i = 0; i < 4; i++) begin
            held = {bus.resp_write, bus.resp_ok, bus.resp_mismatch, bus.resp_unwritten};
            chk("t4_resp_valid", bus.resp_valid, 1'b1);
            chk("t4_resp_fields", held, 4'b0100);
            chk("t4_req_ready", bus.req_ready, 1'b0);
            @(negedge clk);
        end
        bus.req_valid = 1'b0;
        ack_resp();
        read_chk("t4_ignored", 6'd20, 8'h55, 1'b0, 1'b0, 1'b1);

        // second mismatch at another address: err_addr must stay at the first one
        write_chk("irq_wr", 6'd12, 8'h10);
        read_chk("irq_rd", 6'd12, 8'h11, 1'b0, 1'b1, 1'b0);
        chk("irq_err_count", err_count, 16'd2);
`ifdef TAG_CHECK_IRQ_EN
        chk("irq_sticky_addr", err_addr, 6'd5);
        irq_clr = 1'b1;
        @(negedge clk);
        irq_clr = 1'b0;
        chk("irq_clr_irq", err_irq, 1'b0);
        chk("irq_clr_addr", err_addr, 6'd0);
        irq_clr = 1'b1;
`endif
        // irq_clr (when present) is held across this mismatch and must win
        read_chk("clr_rd", 6'd12, 8'h11, 1'b0, 1'b1, 1'b0);
        irq_clr = 1'b0;
        chk("clr_err_count", err_count, 16'd3);
        chk("sat_reach_s", err_count_s, 2'd3);
`ifdef TAG_CHECK_IRQ_EN
        chk("clr_wins_irq", err_irq, 1'b0);
        chk("clr_wins_addr", err_addr, 6'd0);
`endif

        // 5: saturation (2-bit instance) while the 16-bit counter keeps counting
        for (int i = 0; i < 2; i++) begin
            read_chk("t5_rd", 6'd5, 8'hA2, 1'b0, 1'b1, 1'b0);
            chk("t5_sat_s", err_count_s, 2'd3);
        end
        chk("t5_err_count", err_count, 16'd5);
`ifdef TAG_CHECK_IRQ_EN
        chk("t5_rearm_irq", err_irq, 1'b1);
        chk("t5_rearm_addr", err_addr, 6'd5);
`endif

        // 6: reset during LOOKUP aborts the read and clears valid bits
        write_chk("t6_wr", 6'd7, 8'h3C);
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_addr  = 6'd7;
        bus.req_tag   = 8'h3C;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("t6_req_ready", bus.req_ready, 1'b1);
        chk("t6_resp_valid", bus.resp_valid, 1'b0);
        chk("t6_err_count", err_count, 16'd0);
        chk("t6_err_count_s", err_count_s, 2'd0);
        @(negedge clk);
        chk("t6_no_resp", bus.resp_valid, 1'b0);
        read_chk("t6_rd", 6'd7, 8'h3C, 1'b0, 1'b0, 1'b1);

        // write accepted on a reset edge is discarded
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_addr  = 6'd3;
        bus.req_tag   = 8'h77;
        reset = 1'b1;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        chk("rstwr_resp_valid", bus.resp_valid, 1'b0);
        read_chk("rstwr_rd", 6'd3, 8'h77, 1'b0, 1'b0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
